// File: rtl/aes128_round_ctrl_pkg.sv
// Shared AES-128 constants, FSM state type and byte-level round functions
// used by the round controller and its key-expansion step.
package aes128_pkg;

   localparam int NR = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2
   } fsm_e;

   // Entry 0 is unused so the table is indexed directly by the round number.
   localparam logic [7:0] RCON [0:10] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Out-of-range counts map to zero so a corrupted counter cannot index past the table.
   function automatic logic [7:0] rconFor(input logic [3:0] idx);
      return (idx <= 4'(NR)) ? RCON[idx] : 8'h00;
   endfunction

   function automatic logic [127:0] subBytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      end
      return r;
   endfunction

   function automatic logic [127:0] mixColumns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

endpackage

// File: rtl/aes128_round_ctrl_if.sv
// Request/response bundle between the register front-end (master) and the
// AES round controller (slave).
interface aes128_round_ctrl_if;
   logic         start;
   logic [127:0] key_in;
   logic [127:0] data_in;
   logic [127:0] data_out;
   logic         busy;
   logic         done;

   modport master (output start, key_in, data_in, input data_out, busy, done);
   modport slave  (input start, key_in, data_in, output data_out, busy, done);
endinterface

// File: rtl/aes128_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one.
module aes128_key_step
   import aes128_pkg::*;
(
   input  logic [127:0] rk_in,
   input  logic [7:0]   rcon,
   output logic [127:0] rk_out
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rotWord, subWord, temp;
   logic [31:0] w4, w5, w6, w7;

   assign {w0, w1, w2, w3} = rk_in;
   assign rotWord = {w3[23:0], w3[31:24]};
   assign subWord = {sbox(rotWord[31:24]), sbox(rotWord[23:16]),
                     sbox(rotWord[15:8]),  sbox(rotWord[7:0])};
   assign temp    = subWord ^ {rcon, 24'h000000};

   assign w4 = w0 ^ temp;
   assign w5 = w1 ^ w4;
   assign w6 = w2 ^ w5;
   assign w7 = w3 ^ w6;

   assign rk_out = {w4, w5, w6, w7};

endmodule

// File: rtl/shiftrows.sv
// AES ShiftRows byte permutation on a column-major state, byte 0 at [127:120].
// done_sr is a legacy ready flag; the permutation is purely combinational.
module shiftrows (
   input  logic [127:0] sr_in,
   output logic [127:0] sr_out,
   output logic         done_sr
);

   // Row r of column c takes the byte from column (c + r) mod 4 of the same row.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign sr_out[127-8*(r+4*c) -: 8] = sr_in[127-8*(r+4*((c+r)%4)) -: 8];
      end
   end

   assign done_sr = 1'b1;

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, round keys
// expanded on the fly, ciphertext returned with a one-cycle done pulse.
module aes128_round_ctrl
   import aes128_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   aes128_round_ctrl_if.slave bus
);

   fsm_e         fsm_q, fsm_d;
   logic [3:0]   round_cnt_q, round_cnt_d;
   logic [127:0] state_reg_q, state_reg_d;
   logic [127:0] rk_q, rk_d;
   logic [127:0] data_out_q, data_out_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [127:0] subOut;
   logic [127:0] srOut;
   logic [127:0] rkNext;
   logic         done_sr_unused;

   // ROUND and FINAL both start from ShiftRows(SubBytes(state)); only the tail differs.
   assign subOut = subBytes(state_reg_q);

   shiftrows u_shiftrows (
      .sr_in   (subOut),
      .sr_out  (srOut),
      .done_sr (done_sr_unused)
   );

   aes128_key_step u_key_step (
      .rk_in  (rk_q),
      .rcon   (rconFor(round_cnt_q)),
      .rk_out (rkNext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= IDLE;
         round_cnt_q <= '0;
         state_reg_q <= '0;
         rk_q        <= '0;
         data_out_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         round_cnt_q <= round_cnt_d;
         state_reg_q <= state_reg_d;
         rk_q        <= rk_d;
         data_out_q  <= data_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // done is a pulse, so it defaults low; all other state holds unless updated.
   always_comb begin
      fsm_d       = fsm_q;
      round_cnt_d = round_cnt_q;
      state_reg_d = state_reg_q;
      rk_d        = rk_q;
      data_out_d  = data_out_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      unique case (fsm_q)
         IDLE: begin
            if (bus.start) begin
               state_reg_d = bus.data_in ^ bus.key_in;
               rk_d        = bus.key_in;
               round_cnt_d = 4'd1;
               busy_d      = 1'b1;
               fsm_d       = ROUND;
            end
         end
         ROUND: begin
            state_reg_d = mixColumns(srOut) ^ rkNext;
            rk_d        = rkNext;
            round_cnt_d = round_cnt_q + 4'd1;
            if (round_cnt_q >= 4'(NR - 1)) begin
               fsm_d = FINAL;
            end
         end
         FINAL: begin
            state_reg_d = srOut ^ rkNext;
            data_out_d  = srOut ^ rkNext;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            round_cnt_d = '0;
            fsm_d       = IDLE;
         end
         default: begin
            fsm_d       = IDLE;
            round_cnt_d = '0;
            busy_d      = 1'b0;
         end
      endcase
   end

   assign bus.data_out = data_out_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Scoreboard bench for the AES-128 round controller using FIPS-197 vectors,
// back-to-back starts, ignored mid-block starts and asynchronous reset.
module tb_aes128_round_ctrl;

   localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] R0V2 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] R1V2 = 128'ha49c7ff2689f352b6b5bea43026a5049;

   logic clk;
   logic rst;
   int   testCount;
   int   failCount;
   int   doneCount;
   int   lat;
   logic [127:0] sbQueue [$];

   aes128_round_ctrl_if bus ();

   aes128_round_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one start pulse across edge T; returns 1ns after that edge.
   task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt,
                                input logic [127:0] exp, input bit pushIt);
      bus.key_in  = key;
      bus.data_in = pt;
      bus.start   = 1'b1;
      if (pushIt) sbQueue.push_back(exp);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic waitDone(input int n0, output int n);
      n = n0;
      while (bus.done !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // Every done pulse must match the oldest outstanding expected ciphertext.
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         doneCount++;
         if (sbQueue.size() == 0) begin
            checkOutput("unexpectedDone", 128'(1), 128'(0));
         end else begin
            checkOutput("cipher", bus.data_out, sbQueue.pop_front());
            checkOutput("busyAtDone", 128'(bus.busy), 128'(0));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      testCount   = 0;
      failCount   = 0;
      doneCount   = 0;
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.key_in  = '0;
      bus.data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstDataOut", bus.data_out, 128'(0));
      checkOutput("rstBusy", 128'(bus.busy), 128'(0));
      checkOutput("rstDone", 128'(bus.done), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] vector 1");
      applyStimulus(KEY1, PT1, CT1, 1'b1);
      checkOutput("busyAfterStart", 128'(bus.busy), 128'(1));
      waitDone(0, lat);
      checkOutput("latencyV1", 128'(lat), 128'(10));
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] vector 2 with round states");
      applyStimulus(KEY2, PT2, CT2, 1'b1);
      checkOutput("round0State", dut.state_reg_q, R0V2);
      @(posedge clk);
      #1;
      checkOutput("round1State", dut.state_reg_q, R1V2);
      waitDone(1, lat);
      checkOutput("latencyV2", 128'(lat), 128'(10));
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] start held high for three blocks");
      bus.key_in  = KEY1;
      bus.data_in = PT1;
      bus.start   = 1'b1;
      for (int b = 0; b < 3; b++) sbQueue.push_back(CT1);
      for (int k = 0; k <= 32; k++) begin
         @(posedge clk);
         #1;
         checkOutput("heldDone", 128'(bus.done), 128'((k % 11) == 10));
         checkOutput("heldBusy", 128'(bus.busy), 128'((k % 11) != 10));
         if (k == 22) bus.start = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] start during block is ignored");
      applyStimulus(KEY1, PT1, CT1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      bus.key_in  = KEY2;
      bus.data_in = PT2;
      bus.start   = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      waitDone(4, lat);
      checkOutput("latencyIgnored", 128'(lat), 128'(10));
      repeat (12) @(posedge clk);
      #1;
      checkOutput("noSecondDone", 128'(doneCount), 128'(6));

      $display("[TB] async reset mid-block");
      applyStimulus(KEY2, PT2, CT2, 1'b0);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("midRstDataOut", bus.data_out, 128'(0));
      checkOutput("midRstBusy", 128'(bus.busy), 128'(0));
      checkOutput("midRstDone", 128'(bus.done), 128'(0));
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("noDoneAfterRst", 128'(doneCount), 128'(6));
      applyStimulus(KEY2, PT2, CT2, 1'b1);
      waitDone(0, lat);
      checkOutput("latencyAfterRst", 128'(lat), 128'(10));

      $display("[TB] idle hold");
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         checkOutput("idleDataOut", bus.data_out, CT2);
         checkOutput("idleDone", 128'(bus.done), 128'(0));
         checkOutput("idleBusy", 128'(bus.busy), 128'(0));
      end

      checkOutput("sbEmpty", 128'(sbQueue.size()), 128'(0));
      checkOutput("doneTotal", 128'(doneCount), 128'(7));
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
